dot_product_operand_streamer: RTL and testbench

//  Successor to the fixed dot-product memory controller. Holds banked A/B

---
 rtl/dot_product_operand_streamer_pkg.sv | 15 +
 rtl/dot_product_operand_streamer_bank.sv | 101 ++++++++++
 rtl/dot_product_operand_streamer.sv | 148 ++++++++++++++
 tb/tb_dot_product_operand_streamer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_operand_streamer_pkg.sv
// Shared types for the dot-product operand streamer.
package dot_product_operand_streamer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stream_state_t;

    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_BIAS = 2'd2
    } wr_sel_t;

endpackage

// File: rtl/dot_product_operand_streamer_bank.sv
// One operand bank: A/B element arrays, bias register, read pointer,
// exhausted flag and the registered read path feeding one dot-product unit.
module dot_product_operand_streamer_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     rd_en,
    input  logic                     req,
    input  logic                     wrap,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     we_a,
    input  logic                     we_b,
    input  logic                     we_bias,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     valid,
    output logic                     last,
    output logic [DATA_WIDTH-1:0]    a_out,
    output logic [DATA_WIDTH-1:0]    b_out,
    output logic [DATA_WIDTH-1:0]    bias_out,
    output logic                     exhausted
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LEN_ONE = (AW + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_a_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_b_q [DEPTH];
    logic [AW-1:0]         ptr_q, ptr_d;
    logic                  exh_q, exh_d;
    logic                  valid_q, last_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, bias_q;
    logic                  fire;
    logic                  at_end;

    assign fire   = rd_en && req && !exh_q;
    assign at_end = ({1'b0, ptr_q} == (len - LEN_ONE));

    // Pointer advance / wrap and one-shot exhaustion.
    always_comb begin
        ptr_d = ptr_q;
        exh_d = exh_q;
        if (clr) begin
            ptr_d = '0;
            exh_d = 1'b0;
        end else if (fire) begin
            ptr_d = at_end ? '0 : ptr_q + PTR_ONE;
            if (at_end && !wrap) begin
                exh_d = 1'b1;
            end
        end
    end

    // Operand storage; not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_a_q[wr_addr] <= wr_data;
        end
        if (we_b) begin
            mem_b_q[wr_addr] <= wr_data;
        end
    end

    // Registered read path, valid/last pulses, pointer and bias registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            exh_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            bias_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            exh_q   <= exh_d;
            valid_q <= fire;
            last_q  <= fire && at_end;
            if (fire) begin
                // Reads see the pre-write contents on a same-cycle collision.
                a_q <= mem_a_q[ptr_q];
                b_q <= mem_b_q[ptr_q];
            end
            if (we_bias) begin
                bias_q <= wr_data;
            end
        end
    end

    assign valid     = valid_q;
    assign last      = last_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign bias_out  = bias_q;
    assign exhausted = exh_q;

endmodule

// File: rtl/dot_product_operand_streamer.sv
// Streams banked A/B operands and a per-unit bias to NUM_UNITS dot-product
// units. Holds the run FSM, the length/mode latch and the write decode.
module dot_product_operand_streamer
    import dot_product_operand_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS  = 4,
    parameter int DEPTH      = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  wrap_mode,
    input  logic [$clog2(DEPTH):0]                vec_len,
    input  logic                                  stop,
    input  logic                                  wr_en,
    input  logic [1:0]                            wr_sel,
    input  logic [$clog2(NUM_UNITS)-1:0]          wr_unit,
    input  logic [$clog2(DEPTH)-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    input  logic [NUM_UNITS-1:0]                  done_array,
    output logic [NUM_UNITS-1:0]                  valid_array,
    output logic [NUM_UNITS-1:0]                  last_array,
    output logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  a_in_array,
    output logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  b_in_array,
    output logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  bias_array,
    output logic                                  busy,
    output logic                                  all_done,
    output logic                                  cfg_err
);

    // state | meaning
    // IDLE  | waiting for a valid start; writes only
    // RUN   | serving per-unit element requests

    localparam int          AW      = $clog2(DEPTH);
    localparam int          UW      = $clog2(NUM_UNITS);
    localparam logic [AW:0] LEN_MAX = (AW + 1)'(DEPTH);

    stream_state_t         state_q, state_d;
    logic [AW:0]           len_q;
    logic                  wrap_q;
    logic                  clr;
    logic                  cfg_err_q, cfg_err_d;
    logic                  all_done_q, all_done_d;
    logic                  rd_en;
    logic                  len_ok;
    logic [NUM_UNITS-1:0]  exhausted;
    logic [NUM_UNITS-1:0]  we_a, we_b, we_bias;

    assign len_ok = (vec_len != '0) && (vec_len <= LEN_MAX);
    assign rd_en  = (state_q == RUN) && !stop;

    // Next state, pointer clear on accepted start, and status pulses.
    always_comb begin
        state_d    = state_q;
        clr        = 1'b0;
        cfg_err_d  = 1'b0;
        all_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = RUN;
                        clr     = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!wrap_q && (&exhausted)) begin
                    // Exhaustion and the final valid land on the same edge,
                    // so the last element is already on the outputs here.
                    state_d    = IDLE;
                    all_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, status pulses and the length/mode latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cfg_err_q  <= 1'b0;
            all_done_q <= 1'b0;
            len_q      <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_err_q  <= cfg_err_d;
            all_done_q <= all_done_d;
            if (clr) begin
                len_q  <= vec_len;
                wrap_q <= wrap_mode;
            end
        end
    end

    // Write strobe decode to the selected bank and target.
    always_comb begin
        we_a    = '0;
        we_b    = '0;
        we_bias = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (wr_en && (wr_unit == UW'(u))) begin
                we_a[u]    = (wr_sel_t'(wr_sel) == SEL_A);
                we_b[u]    = (wr_sel_t'(wr_sel) == SEL_B);
                we_bias[u] = (wr_sel_t'(wr_sel) == SEL_BIAS);
            end
        end
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_bank
        dot_product_operand_streamer_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .clr       (clr),
            .rd_en     (rd_en),
            .req       (done_array[u]),
            .wrap      (wrap_q),
            .len       (len_q),
            .we_a      (we_a[u]),
            .we_b      (we_b[u]),
            .we_bias   (we_bias[u]),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .valid     (valid_array[u]),
            .last      (last_array[u]),
            .a_out     (a_in_array[u]),
            .b_out     (b_in_array[u]),
            .bias_out  (bias_array[u]),
            .exhausted (exhausted[u])
        );
    end

    assign busy     = (state_q == RUN);
    assign all_done = all_done_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_dot_product_operand_streamer.sv
// Directed bench for the dot-product operand streamer.
module tb_dot_product_operand_streamer;

    localparam int DW    = 16;
    localparam int NU    = 4;
    localparam int DEPTH = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic                     wrap_mode;
    logic [4:0]               vec_len;
    logic                     stop;
    logic                     wr_en;
    logic [1:0]               wr_sel;
    logic [1:0]               wr_unit;
    logic [3:0]               wr_addr;
    logic [DW-1:0]            wr_data;
    logic [NU-1:0]            done_array;
    logic [NU-1:0]            valid_array;
    logic [NU-1:0]            last_array;
    logic [NU-1:0][DW-1:0]    a_in_array;
    logic [NU-1:0][DW-1:0]    b_in_array;
    logic [NU-1:0][DW-1:0]    bias_array;
    logic                     busy;
    logic                     all_done;
    logic                     cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    dot_product_operand_streamer #(
        .DATA_WIDTH (DW),
        .NUM_UNITS  (NU),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .wrap_mode   (wrap_mode),
        .vec_len     (vec_len),
        .stop        (stop),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_unit     (wr_unit),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done_array  (done_array),
        .valid_array (valid_array),
        .last_array  (last_array),
        .a_in_array  (a_in_array),
        .b_in_array  (b_in_array),
        .bias_array  (bias_array),
        .busy        (busy),
        .all_done    (all_done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] sel, input logic [1:0] unit,
                         input logic [3:0] addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_unit = unit;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] len, input logic wrap);
        vec_len   = len;
        wrap_mode = wrap;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        wrap_mode  = 1'b0;
        vec_len    = '0;
        stop       = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = '0;
        wr_unit    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        done_array = '0;
        tick();
        tick();

        // Reset values
        check("rst_valid", valid_array, 0);
        check("rst_last", last_array, 0);
        check("rst_busy", busy, 0);
        check("rst_all_done", all_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_a", a_in_array, 0);
        check("rst_bias", bias_array, 0);
        reset = 1'b0;
        tick();

        // Load A=16u+i, B=i+1, bias=100+u
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < DEPTH; i++) begin
                write(2'd0, 2'(u), 4'(i), DW'(16 * u + i));
                write(2'd1, 2'(u), 4'(i), DW'(i + 1));
            end
            write(2'd2, 2'(u), 4'd0, DW'(100 + u));
            write(2'd3, 2'(u), 4'd0, 16'hDEAD);
        end
        check("bias0", bias_array[0], 100);
        check("bias3", bias_array[3], 103);

        // One-shot, len 4, all units back-to-back
        start_run(5'd4, 1'b0);
        check("t2_busy", busy, 1);
        done_array = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t2_valid%0d", k), valid_array, 4'b1111);
            check($sformatf("t2_a2_%0d", k), a_in_array[2], 32 + k);
            check($sformatf("t2_b0_%0d", k), b_in_array[0], k + 1);
            check($sformatf("t2_last%0d", k), last_array, (k == 3) ? 4'b1111 : 4'b0000);
        end
        check("t2_done_early", all_done, 0);
        tick();
        check("t2_valid_after", valid_array, 0);
        check("t2_a2_hold", a_in_array[2], 35);
        check("t2_all_done", all_done, 1);
        check("t2_busy_fall", busy, 0);
        done_array = 4'b0000;
        tick();
        check("t2_all_done_pulse", all_done, 0);

        // One-shot, len 3, units 1 and 3 requested every other cycle
        start_run(5'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            done_array = 4'b1010;
            tick();
            check($sformatf("t3_valid%0d", k), valid_array, 4'b1010);
            check($sformatf("t3_a1_%0d", k), a_in_array[1], 16 + k);
            check($sformatf("t3_a3_%0d", k), a_in_array[3], 48 + k);
            check($sformatf("t3_last%0d", k), last_array, (k == 2) ? 4'b1010 : 4'b0000);
            done_array = 4'b0000;
            tick();
            check($sformatf("t3_gap%0d", k), valid_array, 0);
        end
        check("t3_still_busy", busy, 1);
        check("t3_no_done", all_done, 0);
        done_array = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t3b_valid%0d", k), valid_array, 4'b0101);
            check($sformatf("t3b_a2_%0d", k), a_in_array[2], 32 + k);
        end
        check("t3b_last", last_array, 4'b0101);
        done_array = 4'b0000;
        tick();
        check("t3_all_done", all_done, 1);
        check("t3_busy", busy, 0);

        // Wrap, len 3, unit 0 held 7 cycles, then stop
        start_run(5'd3, 1'b1);
        done_array = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("t4_valid%0d", k), valid_array, 4'b0001);
            check($sformatf("t4_a0_%0d", k), a_in_array[0], k % 3);
            check($sformatf("t4_last%0d", k), last_array, (k == 2 || k == 5) ? 4'b0001 : 4'b0000);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        done_array = 4'b0000;
        check("t4_stop_valid", valid_array, 0);
        check("t4_stop_busy", busy, 0);
        check("t4_stop_no_done", all_done, 0);

        // Read-before-write collision on A[1][2]
        start_run(5'd3, 1'b1);
        done_array = 4'b0010;
        tick();
        check("t6_a1_i0", a_in_array[1], 16);
        tick();
        check("t6_a1_i1", a_in_array[1], 17);
        wr_en   = 1'b1;
        wr_sel  = 2'd0;
        wr_unit = 2'd1;
        wr_addr = 4'd2;
        wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        check("t6_old_value", a_in_array[1], 18);
        tick();
        check("t6_wrap_i0", a_in_array[1], 16);
        tick();
        tick();
        check("t6_new_value", a_in_array[1], 16'hBEEF);
        check("t6_last", last_array, 4'b0010);
        done_array = 4'b0000;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t6_stopped", busy, 0);

        // Rejected starts
        start_run(5'd0, 1'b0);
        check("t5_err_len0", cfg_err, 1);
        check("t5_busy_len0", busy, 0);
        tick();
        check("t5_err_pulse", cfg_err, 0);
        start_run(5'd17, 1'b0);
        check("t5_err_len17", cfg_err, 1);
        check("t5_busy_len17", busy, 0);
        tick();

        // Full-depth one-shot
        start_run(5'd16, 1'b0);
        check("t5_err_len16", cfg_err, 0);
        check("t5_busy_len16", busy, 1);
        done_array = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("t5_a3_%0d", k), a_in_array[3], 48 + k);
            check($sformatf("t5_last%0d", k), last_array, (k == 15) ? 4'b1111 : 4'b0000);
        end
        done_array = 4'b0000;
        tick();
        check("t5_all_done", all_done, 1);
        check("t5_busy_fall", busy, 0);

        // Async reset mid-run, memory retained
        start_run(5'd4, 1'b0);
        done_array = 4'b1111;
        tick();
        tick();
        check("t1_pre_valid", valid_array, 4'b1111);
        #2;
        reset = 1'b1;
        #1;
        check("t1_valid", valid_array, 0);
        check("t1_last", last_array, 0);
        check("t1_a", a_in_array, 0);
        check("t1_b", b_in_array, 0);
        check("t1_bias", bias_array, 0);
        check("t1_busy", busy, 0);
        check("t1_all_done", all_done, 0);
        done_array = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        start_run(5'd4, 1'b0);
        done_array = 4'b0100;
        tick();
        check("t1_mem_a0", a_in_array[2], 32);
        check("t1_mem_b0", b_in_array[2], 1);
        tick();
        check("t1_mem_a1", a_in_array[2], 33);
        done_array = 4'b0000;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t1_end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
